// File: rtl/aes_cbc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// aes_cbc_ctrl_pkg
//   Shared constants for the AES block-mode controller and its cipher core
//   interface: block/counter widths, chaining-mode encodings, core handshake
//   levels and the controller state encoding. Also holds the helper that
//   forms the block presented to the core.
// ---------------------------------------------------------------------------
package aes_cbc_ctrl_pkg;

  localparam int BLOCK_W = 128;
  localparam int CNT_W   = 32;

  // Chaining modes
  localparam logic MODE_ECB = 1'b0;
  localparam logic MODE_CBC = 1'b1;

  // Core control levels: core_ready is high while the core is idle/done
  localparam logic CORE_IDLE = 1'b1;
  localparam logic CORE_BUSY = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_WAIT_LO = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  // Block handed to the core: plaintext alone in ECB, whitened with the
  // chaining value in CBC.
  function automatic logic [BLOCK_W-1:0] form_block(
    input logic [BLOCK_W-1:0] data,
    input logic [BLOCK_W-1:0] chain,
    input logic               blk_mode
  );
    return (blk_mode == MODE_CBC) ? (data ^ chain) : data;
  endfunction

endpackage

// File: rtl/aes_cbc_ctrl.sv
// ---------------------------------------------------------------------------
// aes_cbc_ctrl
//   Sequences one 128-bit block at a time through an external cipher core in
//   ECB or CBC mode, with ready/valid handshakes on both sides.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-low
//   mode         0 = ECB, 1 = CBC, sampled when a block is accepted
//   iv, iv_load  chaining value and its load strobe (honoured in IDLE only)
//   in_valid/in_ready/in_data      upstream plaintext handshake
//   core_init    one-cycle start pulse to the core
//   core_block   registered block presented to the core
//   core_result  core output block
//   core_ready   core idle/done flag (drops after init, rises when done)
//   out_valid/out_ready/out_data   downstream ciphertext handshake
//   blk_count    number of completed (handed-off) blocks, wraps mod 2^32
// ---------------------------------------------------------------------------
module aes_cbc_ctrl
  import aes_cbc_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               mode,
  input  logic [BLOCK_W-1:0] iv,
  input  logic               iv_load,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BLOCK_W-1:0] in_data,
  output logic               core_init,
  output logic [BLOCK_W-1:0] core_block,
  input  logic [BLOCK_W-1:0] core_result,
  input  logic               core_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_data,
  output logic [CNT_W-1:0]   blk_count
);

  state_t             state_reg, state_next;
  logic               mode_reg, mode_next;
  logic [BLOCK_W-1:0] chain_reg, chain_next;
  logic [BLOCK_W-1:0] core_block_reg, core_block_next;
  logic [BLOCK_W-1:0] out_data_reg, out_data_next;
  logic [CNT_W-1:0]   blk_count_reg, blk_count_next;

  // Chaining value seen by a block accepted this cycle: a coincident iv_load
  // wins so the block uses the freshly loaded iv.
  logic [BLOCK_W-1:0] chain_eff;
  assign chain_eff = iv_load ? iv : chain_reg;

  always_comb begin
    state_next      = state_reg;
    mode_next       = mode_reg;
    chain_next      = chain_reg;
    core_block_next = core_block_reg;
    out_data_next   = out_data_reg;
    blk_count_next  = blk_count_reg;
    in_ready        = 1'b0;
    core_init       = 1'b0;
    out_valid       = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        in_ready = (core_ready == CORE_IDLE);
        if (iv_load) begin
          chain_next = iv;
        end
        if (in_valid && core_ready == CORE_IDLE) begin
          mode_next       = mode;
          core_block_next = form_block(in_data, chain_eff, mode);
          state_next      = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        core_init  = 1'b1;
        state_next = ST_WAIT_LO;
      end

      // Wait for the core to acknowledge the start by dropping ready, so a
      // still-high ready from the previous block is not mistaken for done.
      ST_WAIT_LO: begin
        if (core_ready == CORE_BUSY) begin
          state_next = ST_WAIT_HI;
        end
      end

      ST_WAIT_HI: begin
        if (core_ready == CORE_IDLE) begin
          out_data_next = core_result;
          if (mode_reg == MODE_CBC) begin
            chain_next = core_result;
          end
          state_next = ST_OUT;
        end
      end

      ST_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          blk_count_next = blk_count_reg + 1'b1;
          state_next     = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      mode_reg       <= MODE_ECB;
      chain_reg      <= '0;
      core_block_reg <= '0;
      out_data_reg   <= '0;
      blk_count_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      mode_reg       <= mode_next;
      chain_reg      <= chain_next;
      core_block_reg <= core_block_next;
      out_data_reg   <= out_data_next;
      blk_count_reg  <= blk_count_next;
    end
  end

  assign core_block = core_block_reg;
  assign out_data   = out_data_reg;
  assign blk_count  = blk_count_reg;

endmodule
